// File: rtl/mul_issue.sv
`timescale 1ns / 1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | mul_issue: operand issue / result capture around the Booth core `mul`. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mul_issue #(
  parameter int XLEN       = 32,
  parameter int MUL_BITS   = XLEN + 2,
  parameter int MUL_CYCLES = 1 + MUL_BITS / 2
) (
  input  logic                clk,
  input  logic                syn_rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  input  logic                in_a_signed,
  input  logic                in_b_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_hi,
  output logic [XLEN-1:0]     out_lo,
  output logic                busy,
  output logic                err,
  output logic                mul_en,
  output logic                mul_syn_rst,
  output logic [MUL_BITS-1:0] mul_multiplicand,
  output logic [MUL_BITS-1:0] mul_multiplier,
  input  logic                mul_outvalid,
  input  logic [MUL_BITS-1:0] mul_result_hi,
  input  logic [MUL_BITS-1:0] mul_result_lo
);

  localparam int              CNT_W    = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CAPT = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MUL_BITS-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                err_q, err_d;
  logic                accept;
  logic                unused_hi;

  // Product bits above 63 are never returned.
  assign unused_hi = ^mul_result_hi[MUL_BITS-1:XLEN-2];

  assign in_ready = !syn_rst && !flush &&
                    ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = err_q;
    if (accept) begin
      mcand_d  = {{2{in_a[XLEN-1] & in_a_signed}}, in_a};
      mplier_d = {{2{in_b[XLEN-1] & in_b_signed}}, in_b};
    end
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_d = CAPT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CAPT: begin
          if (mul_outvalid) begin
            lo_d    = mul_result_lo[XLEN-1:0];
            hi_d    = {mul_result_hi[XLEN-3:0], mul_result_lo[MUL_BITS-1:XLEN]};
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = accept ? RUN : IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      err_q    <= err_d;
    end
  end

  // Outputs read as reset values for the whole time syn_rst is high.
  assign out_valid        = !syn_rst && (state_q == DONE);
  assign busy             = !syn_rst && (state_q != IDLE);
  assign mul_en           = !syn_rst && (state_q == RUN);
  assign err              = !syn_rst && err_q;
  assign out_hi           = syn_rst ? '0 : hi_q;
  assign out_lo           = syn_rst ? '0 : lo_q;
  assign mul_multiplicand = syn_rst ? '0 : mcand_q;
  assign mul_multiplier   = syn_rst ? '0 : mplier_q;
  assign mul_syn_rst      = syn_rst || (flush && ((state_q == RUN) || (state_q == CAPT)));

endmodule
`default_nettype wire

// File: tb/tb_mul_issue.sv
`timescale 1ns / 1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mul_issue: directed bench for mul_issue with a behavioural core.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mul_issue;

  logic        clk = 1'b0;
  logic        syn_rst, flush, in_valid, in_ready, in_a_signed, in_b_signed;
  logic [31:0] in_a, in_b, out_hi, out_lo;
  logic        out_valid, out_ready, busy, err, mul_en, mul_syn_rst, mul_outvalid;
  logic [33:0] mul_multiplicand, mul_multiplier, mul_result_hi, mul_result_lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_issue dut (
    .clk(clk), .syn_rst(syn_rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_hi(out_hi), .out_lo(out_lo),
    .busy(busy), .err(err), .mul_en(mul_en), .mul_syn_rst(mul_syn_rst),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_outvalid(mul_outvalid), .mul_result_hi(mul_result_hi), .mul_result_lo(mul_result_lo)
  );

  // Core stand-in: loads on the first en, outvalid after 18 en cycles.
  logic [4:0]  s_cnt;
  logic [67:0] s_prod;
  logic        suppress;
  always @(posedge clk) begin
    if (mul_syn_rst) begin
      s_cnt  <= 5'd0;
      s_prod <= 68'd0;
    end else if (mul_en) begin
      if (s_cnt == 5'd0 || s_cnt == 5'd18) begin
        s_prod <= 68'($signed({{34{mul_multiplicand[33]}}, mul_multiplicand}) *
                      $signed({{34{mul_multiplier[33]}}, mul_multiplier}));
        s_cnt  <= 5'd1;
      end else begin
        s_cnt <= s_cnt + 5'd1;
      end
    end
  end
  assign mul_outvalid  = (s_cnt == 5'd18) && !suppress;
  assign mul_result_hi = s_prod[67:34];
  assign mul_result_lo = s_prod[33:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a pair, waits for acceptance and returns in cycle t+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic as, input logic bs, input logic ordy);
    int n;
    in_a = a; in_b = b; in_a_signed = as; in_b_signed = bs;
    in_valid = 1'b1; out_ready = ordy;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ext_a", 64'(mul_multiplicand), 64'({{2{a[31] & as}}, a}));
    check("ext_b", 64'(mul_multiplier), 64'({{2{b[31] & bs}}, b}));
  endtask

  // Starting in cycle t+1, waits for out_valid and checks latency and data.
  task automatic wait_result(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, en;
    lat = 0; en = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (mul_en) en++;
      if (out_valid) break;
      @(posedge clk); #1;
    end
    check({tag, "_lat"}, 64'(lat), 64'd20);
    check({tag, "_en"}, 64'(en), 64'd18);
    check({tag, "_hi"}, 64'(out_hi), 64'(ehi));
    check({tag, "_lo"}, 64'(out_lo), 64'(elo));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic as, input logic bs,
                        input logic [31:0] ehi, input logic [31:0] elo);
    issue(a, b, as, bs, 1'b1);
    wait_result(tag, ehi, elo);
    @(posedge clk); #1;
    check({tag, "_retire"}, 64'(out_valid), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, 64'({in_ready, out_valid, busy, mul_en, err, mul_syn_rst}), 64'b000001);
    check({tag, "_data"}, {out_hi, out_lo}, 64'd0);
    check({tag, "_mc"}, 64'(mul_multiplicand), 64'd0);
    check({tag, "_mp"}, 64'(mul_multiplier), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov;
    syn_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0; suppress = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    syn_rst = 1'b0;
    @(negedge clk);
    check("post_rst", 64'({in_ready, mul_syn_rst, busy}), 64'b100);
    @(posedge clk); #1;

    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("ss_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001);
    run_op("su_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000, 32'h0000_0000);

    // Back-pressure, then retire and accept on the same edge.
    issue(32'd7, 32'd9, 1'b0, 1'b0, 1'b0);
    wait_result("bp", 32'd0, 32'd63);
    in_a = 32'hFFFF_FFFE; in_b = 32'd3; in_a_signed = 1'b1; in_b_signed = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", 64'({out_valid, in_ready, mul_en}), 64'b100);
      check("bp_data", {out_hi, out_lo}, 64'd63);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp2", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    @(posedge clk); #1;

    // Flush in cycle t+7.
    issue(32'h1234, 32'h5678, 1'b0, 1'b0, 1'b1);
    repeat (6) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("fl_pulse", 64'({mul_syn_rst, busy, in_ready}), 64'b110);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_after", 64'({mul_syn_rst, busy, mul_en, in_ready}), 64'b0001);
    ov = 0;
    repeat (25) begin @(negedge clk); if (out_valid) ov++; end
    check("fl_noval", 64'(ov), 64'd0);
    @(posedge clk); #1;
    run_op("fl_3x5", 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd15);

    // Reset in cycle t+12.
    issue(32'h1234, 32'h5678, 1'b0, 1'b0, 1'b1);
    repeat (11) begin @(posedge clk); #1; end
    syn_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_vals("midrst");
      @(posedge clk); #1;
    end
    syn_rst = 1'b0;
    @(negedge clk);
    check("midrst_rel", 64'({in_ready, mul_syn_rst, busy}), 64'b100);
    @(posedge clk); #1;
    run_op("pow16", 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000);

    // Core withholds outvalid in CAPT.
    suppress = 1'b1;
    issue(32'd2, 32'd3, 1'b0, 1'b0, 1'b1);
    ov = 0;
    repeat (25) begin @(negedge clk); if (out_valid) ov++; end
    check("miss_noval", 64'(ov), 64'd0);
    check("miss_state", 64'({busy, err}), 64'b01);
    suppress = 1'b0;
    @(posedge clk); #1;
    run_op("miss_next", 32'd2, 32'd3, 1'b0, 1'b0, 32'd0, 32'd6);
    check("err_sticky", 64'(err), 64'd1);
    syn_rst = 1'b1;
    @(negedge clk);
    check("err_in_rst", 64'(err), 64'd0);
    @(posedge clk); #1;
    syn_rst = 1'b0;
    @(negedge clk);
    check("err_cleared", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_issue.md
# mul_issue

Operand-issue and result-capture stage wrapped around the radix-4 Booth multiplier core `mul` (DATA_BITS = 34). It accepts 32-bit operand pairs over a valid/ready handshake and sign- or zero-extends each operand to 34 bits. It drives the core's `en` for exactly one full multiplication, captures the 68-bit product, and returns the low 64 bits as HI/LO over a valid/ready handshake. It also handles flush and back-pressure.

## Interface
- XLEN, 32, architectural operand width.
- MUL_BITS, 34, core operand width; fixed at XLEN+2.
- MUL_CYCLES, 18, `en` cycles per multiplication: 1 load plus MUL_BITS/2 Booth steps.

Ports:
- clk  in  1  clock, rising edge.
- syn_rst  in  1  reset, synchronous, active-high.
- flush  in  1  abort any in-flight or held operation.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept an operand pair.
- in_a  in  XLEN  multiplicand.
- in_b  in  XLEN  multiplier.
- in_a_signed  in  1  1 = in_a is two's complement; 0 = unsigned.
- in_b_signed  in  1  1 = in_b is two's complement; 0 = unsigned.
- out_valid  out  1  HI/LO result valid.
- out_ready  in  1  consumer takes the result.
- out_hi  out  XLEN  product bits [63:32].
- out_lo  out  XLEN  product bits [31:0].
- busy  out  1  state is not IDLE.
- err  out  1  sticky: core `outvalid` was missing in the capture cycle; cleared only by syn_rst.
- mul_en  out  1  to core `en`.
- mul_syn_rst  out  1  to core `syn_rst`.
- mul_multiplicand  out  MUL_BITS  to core.
- mul_multiplier  out  MUL_BITS  to core.
- mul_outvalid  in  1  from core `outvalid`.
- mul_result_hi  in  MUL_BITS  from core.
- mul_result_lo  in  MUL_BITS  from core.

## Operation
- **FSM states:** IDLE, RUN, CAPT, DONE.
- **Handshakes:**
  - in_ready = !syn_rst & !flush & (IDLE | (DONE & out_ready)).
  - Accept = in_valid & in_ready.
- **Operand extension:** on accept, register the extended operands; they stay stable until the next accept.
  - mul_multiplicand = {2{in_a[XLEN-1] & in_a_signed}, in_a}.
  - mul_multiplier = {2{in_b[XLEN-1] & in_b_signed}, in_b}.
- **IDLE:** on accept, clear cnt and go to RUN.
- **RUN:** mul_en = 1 and cnt increments each cycle. When cnt == MUL_CYCLES-1, go to CAPT. mul_en is 0 in every other state.
- **CAPT:**
  - If mul_outvalid = 1, register out_lo = mul_result_lo[31:0] and out_hi = {mul_result_hi[29:0], mul_result_lo[33:32]}, then go to DONE.
  - Otherwise set err, go to IDLE, and do not assert out_valid.
- **DONE:**
  - out_valid = 1; out_hi/out_lo are held stable while out_ready = 0.
  - out_ready & accept: go to RUN (back-to-back).
  - out_ready without accept: go to IDLE.
- **Flush:**
  - In RUN or CAPT: go to IDLE. mul_syn_rst = 1 combinationally for that cycle, so the core clears on the same edge.
  - In DONE: the result is dropped and the FSM goes to IDLE.
  - In IDLE: no effect, but in_valid is not accepted that cycle.
  - mul_syn_rst = syn_rst | (flush & (RUN | CAPT)).
- **syn_rst:**
  - FSM goes to IDLE; cnt, out_hi, out_lo, err and the operand registers go to 0.
  - Forces mul_syn_rst = 1; overrides flush and in_valid.

## Timing
- **Values while syn_rst is high:** in_ready 0, out_valid 0, busy 0, mul_en 0, err 0, mul_syn_rst 1, all data outputs 0.
- **Values in the first cycle after syn_rst:** in_ready 1, mul_syn_rst 0.
- **Latency** (accept at the edge ending cycle t):
  - mul_en is high in cycles t+1 .. t+18.
  - The core's counter runs 0, 2, …, 34, and its mul_outvalid is high in cycle t+19 (CAPT).
  - out_valid rises in cycle t+20.
  - Accept to out_valid is 20 cycles.
- **Throughput:** with out_ready held high and in_valid continuous, one result per 20 cycles.
- **Output stability:** out_valid/out_hi/out_lo change only at a DONE handshake, a flush or syn_rst.
- **Counter width:** cnt is clog2(MUL_CYCLES) bits and never wraps; RUN always exits at MUL_CYCLES-1.
- **Flush and syn_rst together:** treated as syn_rst.

## Test plan
- **Unsigned max:** a = b = 0xFFFFFFFF, both unsigned → out_hi 0xFFFFFFFE, out_lo 0x00000001; out_valid exactly 20 cycles after accept; mul_en high for exactly 18 cycles.
- **Signed, signed×unsigned and min×min:**
  - −1 × −1, both signed → hi 0x00000000, lo 0x00000001.
  - a = 0xFFFFFFFF signed, b = 0xFFFFFFFF unsigned → hi 0xFFFFFFFF, lo 0x00000001.
  - 0x80000000 × 0x80000000, both signed → hi 0x40000000, lo 0x00000000.
- **Back-pressure:** hold out_ready = 0 for 10 cycles in DONE → out_valid and data stable, in_ready 0, mul_en 0. Then raise out_ready with in_valid high → result retired and new pair accepted in the same cycle; next result correct.
- **Flush:** flush in cycle t+7 of an operation → mul_syn_rst pulses for 1 cycle, FSM to IDLE, no out_valid. A following 3 × 5 (unsigned) → hi 0, lo 15.
- **Reset mid-operation:** syn_rst in cycle t+12 → all outputs at their reset values, mul_syn_rst high throughout; the next operation 0x00010000 × 0x00010000 → hi 0x00000001, lo 0.
- **Missing outvalid:** core stub suppresses outvalid in CAPT → err = 1 and sticky, FSM to IDLE, no out_valid; err cleared only by syn_rst.
